fft_stream_framer: RTL

Streaming front/back end for the array-port FFT engine (fft_controller) used in the convolution path. It accepts samples over a valid/ready stream into an N-point sliding window that advances HOP samples per frame, so overlap-save framing is built in. It starts the engine, waits for the result with a timeout, then streams the N output bins back out with backpressure. This block replaces the manual array load, start pulse and wait-for-valid sequence.

---
 rtl/fft_stream_pkg.sv | 17 +
 rtl/fft_sample_window.sv | 37 +++
 rtl/fft_stream_framer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/fft_stream_pkg.sv
// Shared types and constants for the FFT stream framer.
package fft_stream_pkg;

  typedef enum logic [1:0] {
    StFill,
    StStart,
    StWait,
    StDrain
  } state_e;

  localparam int unsigned FrameCntWidth = 16;

  function automatic int unsigned idx_width(input int unsigned points);
    return $clog2(points);
  endfunction

endpackage

// File: rtl/fft_sample_window.sv
// N-entry complex shift window: index 0 is the oldest sample, new samples enter at N-1.
module fft_sample_window #(
  parameter int unsigned Points = 16,
  parameter int unsigned Width  = 24
) (
  input  logic                    clk_i,
  input  logic                    clear_i,
  input  logic                    shift_i,
  input  logic signed [Width-1:0] din_re_i,
  input  logic signed [Width-1:0] din_im_i,
  output logic signed [Width-1:0] win_re_o [Points],
  output logic signed [Width-1:0] win_im_o [Points]
);

  logic signed [Width-1:0] re_q [Points];
  logic signed [Width-1:0] im_q [Points];

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      for (int i = 0; i < Points; i++) begin
        re_q[i] <= '0;
        im_q[i] <= '0;
      end
    end else if (shift_i) begin
      for (int i = 0; i < Points - 1; i++) begin
        re_q[i] <= re_q[i+1];
        im_q[i] <= im_q[i+1];
      end
      re_q[Points-1] <= din_re_i;
      im_q[Points-1] <= din_im_i;
    end
  end

  assign win_re_o = re_q;
  assign win_im_o = im_q;

endmodule

// File: rtl/fft_stream_framer.sv
// Stream framer around an array-port FFT engine: sliding-window fill, start, timed wait,
// and backpressured drain of the N result bins.
module fft_stream_framer
  import fft_stream_pkg::*;
#(
  parameter int unsigned FFT_POINTS = 1024,
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned OUT_WIDTH  = 40,
  parameter int unsigned HOP        = FFT_POINTS,
  parameter int unsigned TIMEOUT    = 65536
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                in_valid_i,
  output logic                                in_ready_o,
  input  logic signed [DATA_WIDTH-1:0]        in_real_i,
  input  logic signed [DATA_WIDTH-1:0]        in_imag_i,
  input  logic                                forward_inverse_i,
  output logic                                fft_start_o,
  output logic                                fft_forward_inverse_o,
  output logic signed [DATA_WIDTH-1:0]        fft_in_real_o [FFT_POINTS],
  output logic signed [DATA_WIDTH-1:0]        fft_in_imag_o [FFT_POINTS],
  input  logic signed [OUT_WIDTH-1:0]         fft_out_real_i [FFT_POINTS],
  input  logic signed [OUT_WIDTH-1:0]         fft_out_imag_i [FFT_POINTS],
  input  logic                                fft_data_valid_i,
  input  logic                                fft_in_prog_i,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic signed [OUT_WIDTH-1:0]         out_real_o,
  output logic signed [OUT_WIDTH-1:0]         out_imag_o,
  output logic [idx_width(FFT_POINTS)-1:0]    out_index_o,
  output logic                                out_last_o,
  output logic                                fft_timeout_o,
  output logic [FrameCntWidth-1:0]            frame_count_o
);

  localparam int unsigned IdxW  = idx_width(FFT_POINTS);
  localparam int unsigned HopW  = $clog2(HOP + 1);
  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
  localparam logic [HopW-1:0]  HopLast  = HopW'(HOP - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(FFT_POINTS - 1);

  state_e                   state_q, state_d;
  logic [HopW-1:0]          hop_cnt_q, hop_cnt_d;
  logic [WaitW-1:0]         wait_cnt_q, wait_cnt_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic [FrameCntWidth-1:0] frame_q, frame_d;
  logic                     fwd_inv_q, fwd_inv_d;
  logic                     dv_prev_q, dv_prev_d;
  logic                     capture;
  logic                     accept;

  logic signed [OUT_WIDTH-1:0] res_re_q [FFT_POINTS];
  logic signed [OUT_WIDTH-1:0] res_im_q [FFT_POINTS];

  // Engine busy flag is status only; nothing here depends on it.
  logic unused_in_prog;
  assign unused_in_prog = fft_in_prog_i;

  always_comb begin
    state_d       = state_q;
    hop_cnt_d     = hop_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    idx_d         = idx_q;
    frame_d       = frame_q;
    fwd_inv_d     = fwd_inv_q;
    dv_prev_d     = fft_data_valid_i;
    capture       = 1'b0;
    in_ready_o    = 1'b0;
    fft_start_o   = 1'b0;
    out_valid_o   = 1'b0;
    fft_timeout_o = 1'b0;

    unique case (state_q)
      StFill: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          if (hop_cnt_q == HopLast) begin
            hop_cnt_d = '0;
            state_d   = StStart;
          end else begin
            hop_cnt_d = hop_cnt_q + 1'b1;
          end
        end
      end
      StStart: begin
        fft_start_o = 1'b1;
        fwd_inv_d   = forward_inverse_i;
        wait_cnt_d  = '0;
        // A valid already high when WAIT begins must not look like a fresh result.
        dv_prev_d   = 1'b1;
        state_d     = StWait;
      end
      StWait: begin
        if (fft_data_valid_i && !dv_prev_q) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = StDrain;
        end else if (wait_cnt_q == WaitLast) begin
          fft_timeout_o = 1'b1;
          state_d       = StFill;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StDrain: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          if (idx_q == IdxLast) begin
            idx_d     = '0;
            frame_d   = frame_q + 1'b1;
            hop_cnt_d = '0;
            state_d   = StFill;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StFill;
    endcase

    if (reset_i) begin
      in_ready_o    = 1'b0;
      fft_start_o   = 1'b0;
      out_valid_o   = 1'b0;
      fft_timeout_o = 1'b0;
    end
  end

  assign accept = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StFill;
      hop_cnt_q  <= '0;
      wait_cnt_q <= '0;
      idx_q      <= '0;
      frame_q    <= '0;
      fwd_inv_q  <= 1'b0;
      dv_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hop_cnt_q  <= hop_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      fwd_inv_q  <= fwd_inv_d;
      dv_prev_q  <= dv_prev_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < FFT_POINTS; i++) begin
        res_re_q[i] <= '0;
        res_im_q[i] <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < FFT_POINTS; i++) begin
        res_re_q[i] <= fft_out_real_i[i];
        res_im_q[i] <= fft_out_imag_i[i];
      end
    end
  end

  fft_sample_window #(
    .Points(FFT_POINTS),
    .Width (DATA_WIDTH)
  ) u_window (
    .clk_i   (clk_i),
    .clear_i (reset_i),
    .shift_i (accept),
    .din_re_i(in_real_i),
    .din_im_i(in_imag_i),
    .win_re_o(fft_in_real_o),
    .win_im_o(fft_in_imag_o)
  );

  assign fft_forward_inverse_o = fwd_inv_q;
  assign out_real_o            = res_re_q[idx_q];
  assign out_imag_o            = res_im_q[idx_q];
  assign out_index_o           = idx_q;
  assign out_last_o            = (state_q == StDrain) && (idx_q == IdxLast);
  assign frame_count_o         = frame_q;

endmodule
